// File: rtl/raster_pkg.sv
// Shared line-command type, dispatcher state encoding and screen constants.
package raster_pkg;

    localparam int FULL_WIDTH  = 640;
    localparam int FULL_HEIGHT = 480;
    localparam int HALF_WIDTH  = FULL_WIDTH / 2;
    localparam int HALF_HEIGHT = FULL_HEIGHT / 2;

    typedef struct packed {
        logic signed [12:0] start_x;
        logic signed [12:0] start_y;
        logic signed [12:0] end_x;
        logic signed [12:0] end_y;
        logic        [3:0]  color;
    } line_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        FDONE
    } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the search begins at ptr+1 and wraps, so ptr has lowest priority.
// Latency: purely combinational.
// Backpressure: none; the grant depends only on req and ptr.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/raster_dispatcher.sv
// Feeds line commands from N_SRC sources, round-robin, into one shared rasterizer; guards each line with a watchdog.
// Latency: grant is combinational in ARB, issue the cycle after the handshake, back in ARB the cycle after done.
// Backpressure: stalls in ISSUE while rast_ready is low; sources are never granted outside ARB.
module raster_dispatcher
    import raster_pkg::*;
#(
    parameter int N_SRC   = 2,
    parameter int TIMEOUT = 4095,
    parameter int IDW     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC-1:0]        src_last,
    input  line_cmd_t [N_SRC-1:0]   src_cmd,
    output logic [N_SRC-1:0]        src_ready,
    output logic signed [12:0]      rast_start_x,
    output logic signed [12:0]      rast_end_x,
    output logic signed [12:0]      rast_start_y,
    output logic signed [12:0]      rast_end_y,
    output logic [3:0]              rast_color,
    output logic                    rast_ready_in,
    input  logic                    rast_ready,
    input  logic                    rast_done,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id,
    output logic [15:0]             line_count,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    disp_state_t      state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   grant_id_q;
    line_cmd_t        hold_q;
    logic             cur_last_q;
    logic [N_SRC-1:0] last_seen_q;
    logic [N_SRC-1:0] last_seen_d;
    logic [15:0]      line_count_q;
    logic             timeout_err_q;
    logic [WDW-1:0]   wd_q;

    logic [N_SRC-1:0] arb_req;
    logic [N_SRC-1:0] arb_gnt;
    logic [IDW-1:0]   arb_id;
    logic             arb_any;
    logic             wd_expired;

    // Sources that already delivered their final line sit out the rest of the frame.
    assign arb_req = src_valid & ~last_seen_q;

    rr_arbiter #(.N(N_SRC), .IDW(IDW)) u_arb (
        .req    (arb_req),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign src_ready     = (state_q == ARB) ? arb_gnt : '0;
    assign rast_ready_in = (state_q == ISSUE) && rast_ready;
    assign wd_expired    = (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        last_seen_d = last_seen_q;
        if (cur_last_q) begin
            last_seen_d[grant_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDW'(N_SRC - 1);
            grant_id_q    <= '0;
            hold_q        <= '0;
            cur_last_q    <= 1'b0;
            last_seen_q   <= '0;
            line_count_q  <= '0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q       <= ARB;
                        line_count_q  <= '0;
                        last_seen_q   <= '0;
                        timeout_err_q <= 1'b0;
                    end
                end
                ARB: begin
                    if (arb_any) begin
                        hold_q     <= src_cmd[arb_id];
                        cur_last_q <= src_last[arb_id];
                        grant_id_q <= arb_id;
                        rr_ptr_q   <= arb_id;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rast_ready) begin
                        state_q <= WAIT;
                        wd_q    <= '0;
                    end
                end
                WAIT: begin
                    // A done arriving on the expiry cycle still counts as a clean finish.
                    if (rast_done || wd_expired) begin
                        if (!rast_done) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (line_count_q != 16'hFFFF) begin
                            line_count_q <= line_count_q + 16'd1;
                        end
                        last_seen_q <= last_seen_d;
                        state_q     <= (&last_seen_d) ? FDONE : ARB;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                FDONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rast_start_x = hold_q.start_x;
    assign rast_start_y = hold_q.start_y;
    assign rast_end_x   = hold_q.end_x;
    assign rast_end_y   = hold_q.end_y;
    assign rast_color   = hold_q.color;
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_id_q;
    assign line_count   = line_count_q;
    assign frame_done   = (state_q == FDONE);
    assign timeout_err  = timeout_err_q;

endmodule
